// File: rtl/mac_batch_driver_pkg.sv
// Shared types for the MAC batch driver.
// State encoding, slot sizing, complex field helpers.
package mac_batch_driver_pkg;

    typedef enum logic [2:0] {
        SYNC  = 3'd0,
        FILL  = 3'd1,
        START = 3'd2,
        ACK   = 3'd3,
        RUN   = 3'd4,
        OUT   = 3'd5
    } state_t;

    localparam int NSLOT = 4;
    localparam int SW    = 2;

    typedef logic [SW-1:0] slot_t;

    // Packed complex {real, imag}: real is the upper half.
    function automatic int hi_msb(input int w);
        return w - 1;
    endfunction

    function automatic int hi_lsb(input int w);
        return w / 2;
    endfunction

    function automatic int lo_msb(input int w);
        return w / 2 - 1;
    endfunction

endpackage

// File: rtl/mac_batch_driver_operand_bank.sv
// operand_bank: 4-slot x/y register file, all slots visible.
// Ports: clk, rst (sync, active-low), we, idx, wx, wy -> x, y.
module operand_bank
    import mac_batch_driver_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  slot_t                     idx,
    input  logic [DW-1:0]             wx,
    input  logic [DW-1:0]             wy,
    output logic [NSLOT-1:0][DW-1:0]  x,
    output logic [NSLOT-1:0][DW-1:0]  y
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            x <= '0;
            y <= '0;
        end else if (we) begin
            x[idx] <= wx;
            y[idx] <= wy;
        end
    end

endmodule

// File: rtl/mac_batch_driver.sv
// mac_batch_driver: gathers 4 operand pairs, runs MAC start/done
// handshake with a watchdog, returns the result on a valid/ready port.
// Ports: clk, rst (sync, active-low); in_valid/in_ready/in_x/in_y;
// mac_x0..3, mac_y0..3, mac_start, mac_done, mac_result;
// out_valid/out_ready/out_real/out_imag/out_err; busy.
module mac_batch_driver
    import mac_batch_driver_pkg::*;
#(
    parameter int DW      = 8,
    parameter int RW      = 10,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_x,
    input  logic [DW-1:0]   in_y,
    output logic [DW-1:0]   mac_x0,
    output logic [DW-1:0]   mac_x1,
    output logic [DW-1:0]   mac_x2,
    output logic [DW-1:0]   mac_x3,
    output logic [DW-1:0]   mac_y0,
    output logic [DW-1:0]   mac_y1,
    output logic [DW-1:0]   mac_y2,
    output logic [DW-1:0]   mac_y3,
    output logic            mac_start,
    input  logic            mac_done,
    input  logic [2*RW-1:0] mac_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RW-1:0]   out_real,
    output logic [RW-1:0]   out_imag,
    output logic            out_err,
    output logic            busy
);

    state_t                   state;
    slot_t                    cnt;
    logic [TW-1:0]            wdog;
    logic [TW-1:0]            wd_nxt;
    logic                     wd_hit;
    logic                     acc;
    logic [NSLOT-1:0][DW-1:0] bx;
    logic [NSLOT-1:0][DW-1:0] by;

    // in_ready is only high in FILL, so acc implies FILL.
    assign acc    = in_valid & in_ready;
    assign wd_nxt = wdog + 1'b1;
    assign wd_hit = (wd_nxt == TW'(TIMEOUT));

    operand_bank #(.DW(DW)) u_bank (
        .clk (clk),
        .rst (rst),
        .we  (acc),
        .idx (cnt),
        .wx  (in_x),
        .wy  (in_y),
        .x   (bx),
        .y   (by)
    );

    assign mac_x0 = bx[0];
    assign mac_x1 = bx[1];
    assign mac_x2 = bx[2];
    assign mac_x3 = bx[3];
    assign mac_y0 = by[0];
    assign mac_y1 = by[1];
    assign mac_y2 = by[2];
    assign mac_y3 = by[3];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= SYNC;
            cnt       <= '0;
            wdog      <= '0;
            mac_start <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            out_real  <= '0;
            out_imag  <= '0;
            out_err   <= 1'b0;
        end else begin
            mac_start <= 1'b0;
            unique case (state)
                SYNC: begin
                    if (mac_done) begin
                        state    <= FILL;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                FILL: begin
                    if (acc) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == SW'(NSLOT - 1)) begin
                            state     <= START;
                            mac_start <= 1'b1;
                            in_ready  <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                end
                START: begin
                    state <= ACK;
                    wdog  <= '0;
                end
                ACK, RUN: begin
                    wdog <= wd_nxt;
                    // Watchdog wins over a same-cycle done.
                    if (wd_hit) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_err   <= 1'b1;
                        out_real  <= '0;
                        out_imag  <= '0;
                    end else if (state == ACK) begin
                        if (!mac_done) state <= RUN;
                    end else if (mac_done) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                        out_err   <= 1'b0;
                        out_real  <= mac_result[hi_msb(2*RW):hi_lsb(2*RW)];
                        out_imag  <= mac_result[lo_msb(2*RW):0];
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= FILL;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_batch_driver.sv
// Testbench for mac_batch_driver with a behavioural complex MAC.
// Directed vector table plus hand-written multi-cycle sequences.
module tb_mac_batch_driver;

    localparam int DW  = 8;
    localparam int RW  = 10;
    localparam int TO  = 16;
    localparam int TW  = 8;
    localparam int LAT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   in_x = '0;
    logic [DW-1:0]   in_y = '0;
    logic [DW-1:0]   mx [4];
    logic [DW-1:0]   my [4];
    logic            mac_start;
    logic            mac_done;
    logic [2*RW-1:0] mac_result;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [RW-1:0]   out_real;
    logic [RW-1:0]   out_imag;
    logic            out_err;
    logic            busy;

    always #5 clk = ~clk;

    mac_batch_driver #(
        .DW(DW), .RW(RW), .TIMEOUT(TO), .TW(TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .mac_x0     (mx[0]),
        .mac_x1     (mx[1]),
        .mac_x2     (mx[2]),
        .mac_x3     (mx[3]),
        .mac_y0     (my[0]),
        .mac_y1     (my[1]),
        .mac_y2     (my[2]),
        .mac_y3     (my[3]),
        .mac_start  (mac_start),
        .mac_done   (mac_done),
        .mac_result (mac_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .out_err    (out_err),
        .busy       (busy)
    );

    // Behavioural MAC: stuck ignores start, hold forces done low.
    logic            stuck = 1'b0;
    logic            hold  = 1'b1;
    logic            m_done = 1'b1;
    int              m_cnt = 0;
    logic [2*RW-1:0] m_res = '0;

    assign mac_done   = m_done & ~hold;
    assign mac_result = m_res;

    function automatic logic [2*RW-1:0] cmac();
        int re;
        int im;
        re = 0;
        im = 0;
        for (int k = 0; k < 4; k++) begin
            logic signed [3:0] a, b, c, d;
            a = mx[k][7:4];
            b = mx[k][3:0];
            c = my[k][7:4];
            d = my[k][3:0];
            re += int'(a) * int'(c) - int'(b) * int'(d);
            im += int'(a) * int'(d) + int'(b) * int'(c);
        end
        return {RW'(re), RW'(im)};
    endfunction

    always @(posedge clk) begin
        if (m_cnt == 0) begin
            if (mac_start && !stuck) begin
                m_cnt  <= LAT;
                m_done <= 1'b0;
            end
        end else if (m_cnt == 1) begin
            m_cnt  <= 0;
            m_done <= 1'b1;
            m_res  <= cmac();
        end else begin
            m_cnt <= m_cnt - 1;
        end
    end

    int starts = 0;
    int xfers  = 0;

    always @(posedge clk) begin
        if (mac_start) starts <= starts + 1;
        if (out_valid && out_ready) xfers <= xfers + 1;
    end

    typedef struct {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [DW-1:0] ex;
        logic [DW-1:0] ey;
    } vec_t;

    vec_t tbl [4];
    int   nvec = 0;
    int   nerr = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y);
        int n;
        n        = 0;
        in_x     = x;
        in_y     = y;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        if (!in_ready) check("send_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic batch(input int gap);
        int sb;
        sb = starts;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("no_early_start", starts - sb, 0);
            send(tbl[i].x, tbl[i].y);
            if (i == 3) check("start_latency", mac_start, 1);
            for (int g = 0; g < gap; g++) tick();
        end
    endtask

    task automatic wait_out(output int n, output int dt);
        int   td;
        logic pd;
        n  = 0;
        td = -100;
        pd = mac_done;
        while (!out_valid && n < 200) begin
            tick();
            n++;
            if (!pd && mac_done) td = n;
            pd = mac_done;
        end
        check("out_valid_seen", out_valid, 1);
        dt = n - td;
    endtask

    task automatic consume();
        int x0;
        x0        = xfers;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("xfer_count", xfers - x0, 1);
        check("valid_fall", out_valid, 0);
        check("ready_back", in_ready, 1);
    endtask

    task automatic check_result();
        check("real", out_real, 14);
        check("imag", out_imag, 55);
        check("err", out_err, 0);
    endtask

    initial begin
        int n, dt, sb;
        logic seen_v, seen_r;

        tbl[0] = '{x: 8'h23, y: 8'h21, ex: 8'h23, ey: 8'h21};
        tbl[1] = '{x: 8'h22, y: 8'h12, ex: 8'h22, ey: 8'h12};
        tbl[2] = '{x: 8'h10, y: 8'h13, ex: 8'h10, ey: 8'h13};
        tbl[3] = '{x: 8'h62, y: 8'h45, ex: 8'h62, ey: 8'h45};

        // Reset with the MAC reporting busy.
        rst  = 1'b0;
        hold = 1'b1;
        tick();
        tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_start", mac_start, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 1);
        check("rst_out", {out_err, out_real, out_imag}, 0);
        check("rst_ops", {mx[0], mx[1], mx[2], mx[3],
                          my[0], my[1], my[2], my[3]}, 0);
        rst = 1'b1;
        tick();
        check("sync_wait", in_ready, 0);
        hold = 1'b0;
        check("sync_pre", in_ready, 0);
        tick();
        check("sync_fill", in_ready, 1);
        check("fill_busy", busy, 0);

        // Nominal batch.
        sb = starts;
        batch(0);
        wait_out(n, dt);
        check("done_to_valid", dt, 1);
        check("start_count", starts - sb, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mac_x%0d", i), mx[i], tbl[i].ex);
            check($sformatf("mac_y%0d", i), my[i], tbl[i].ey);
        end
        check_result();
        consume();

        // Gaps between pairs.
        sb = starts;
        batch(3);
        wait_out(n, dt);
        check("gap_start_count", starts - sb, 1);
        check_result();
        consume();

        // Backpressure.
        batch(0);
        wait_out(n, dt);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("bp_hold", {out_valid, out_real, out_imag, in_ready},
                  {1'b1, 10'd14, 10'd55, 1'b0});
        end
        consume();
        tick();
        check("bp_single", out_valid, 0);

        // Watchdog timeout with a stuck-idle MAC.
        stuck = 1'b1;
        batch(0);
        wait_out(n, dt);
        check("to_cycles", n, TO + 1);
        check("to_err", out_err, 1);
        check("to_fields", {out_real, out_imag}, 0);
        consume();
        stuck = 1'b0;
        batch(0);
        wait_out(n, dt);
        check_result();
        consume();

        // Reset while the MAC is running.
        batch(0);
        n = 0;
        while (mac_done && n < 50) begin
            tick();
            n++;
        end
        check("run_entered", mac_done, 0);
        tick();
        hold = 1'b1;
        rst  = 1'b0;
        tick();
        rst = 1'b1;
        check("mr_in_ready", in_ready, 0);
        check("mr_busy", busy, 1);
        check("mr_ops", mx[0], 0);
        seen_v = 1'b0;
        seen_r = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            seen_v |= out_valid;
            seen_r |= in_ready;
        end
        check("mr_no_valid", seen_v, 0);
        check("mr_no_ready", seen_r, 0);
        hold = 1'b0;
        check("mr_pre", in_ready, 0);
        tick();
        check("mr_ready", in_ready, 1);
        check("mr_valid", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
